serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (WIDTH >= 2).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port RSTn, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port START, input, 1 bit: operation request, sampled on the CLK rising edge.
REQ-005 The module SHALL have port A, input, WIDTH bits: first operand, captured when START is accepted.
REQ-006 The module SHALL have port B, input, WIDTH bits: second operand, captured when START is accepted.
REQ-007 The module SHALL have port CIN, input, 1 bit: carry-in, captured when START is accepted.
REQ-008 The module SHALL have port BUSY, output, 1 bit: high while a serial addition is in progress.
REQ-009 The module SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port SUM, output, WIDTH bits: result of the last completed addition.
REQ-011 The module SHALL have port COUT, output, 1 bit: carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {COUT,SUM} = A + B + CIN bit-serially, LSB first, using one internal 1-bit full-adder slice (sum = a^b^c, carry = ab|ac|bc) and a carry flip-flop.
REQ-013 The FSM SHALL have states IDLE, RUN and FIN, with IDLE as the reset state.
REQ-014 START SHALL be accepted only when BUSY=0 (state IDLE or FIN); START in RUN SHALL be ignored with no effect on operands, count or outputs.
REQ-015 On an accepted START edge, the block SHALL load A and B into operand shift registers, load the carry flip-flop with CIN, clear the bit counter, and enter RUN.
REQ-016 Each RUN cycle SHALL add operand bit 0 of each register with the carry flip-flop, shift the sum bit into the MSB of the result shift register, shift both operand registers right by one, update the carry flip-flop and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the FSM SHALL enter FIN.
REQ-018 On entering FIN, SUM SHALL take the full result register and COUT the final carry; both SHALL hold until the next completion or reset.
REQ-019 DONE SHALL be high only in FIN, for exactly one cycle; FIN SHALL return to IDLE on the next edge unless START is accepted, in which case it goes directly to RUN.
REQ-020 Latency: with START accepted at edge k, DONE and the new SUM/COUT SHALL be visible after edge k+WIDTH+1.
REQ-021 BUSY SHALL be high in RUN only; it SHALL be low in IDLE and FIN.
REQ-022 SUM and COUT SHALL NOT change during RUN; partial results SHALL stay internal.
REQ-023 Overflow SHALL wrap modulo 2^WIDTH in SUM, with the excess bit in COUT.
REQ-024 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 RSTn low SHALL immediately, regardless of CLK, force state IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, carry flip-flop, counter and shift registers to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation without producing a DONE pulse.
REQ-027 After RSTn deasserts, the first START SHALL be accepted on the next rising edge at which it is high.

Verification
REQ-028 WIDTH=8, A=0x5A, B=0x3C, CIN=0, START pulse -> BUSY high for 8 cycles, then DONE for 1 cycle with SUM=0x96, COUT=0, 9 edges after the START edge.
REQ-029 A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1; A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1.
REQ-030 START re-pulsed in RUN cycle 3 with A=0x00, B=0x00 -> ignored; first operation completes with its original result and DONE pulses once.
REQ-031 START held high in the FIN cycle with new operands 0x10+0x20 -> DONE pulses with the prior result, BUSY reasserts the next cycle, and the next DONE gives SUM=0x30.
REQ-032 RSTn pulsed low in RUN cycle 4, between clock edges -> all outputs are 0 immediately, no DONE follows, and a subsequent START for 0x01+0x01 yields SUM=0x02.
REQ-033 Randomized checks over at least 1000 operand/CIN sets SHALL compare {COUT,SUM} against A+B+CIN with no mismatches.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flip-flop add two
// WIDTH-bit operands LSB first, one bit per clock, over WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic fa_s;
    logic fa_c;
    logic accept;
    logic last;

    always_comb begin
        fa_s = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // START is only honoured when no addition is in flight.
    assign accept = START && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = START ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (accept) begin
                a_sr   <= A;
                b_sr   <= B;
                res_sr <= '0;
                cnt    <= '0;
                carry  <= CIN;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                cnt    <= cnt + CW'(1);
                carry  <= fa_c;
            end
            // Outputs only move on the final bit, so partial sums stay hidden.
            if (last) begin
                sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
                cout_q <= fa_c;
            end
        end
    end

    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);
    assign SUM  = sum_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner sequences
// and randomized operands against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         CLK;
    logic         RSTn;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         COUT;

    int n_chk;
    int n_fail;

    serial_adder #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where DONE is seen.
    task automatic wait_done(input logic [W-1:0] prev, output int nb,
                             output bit stable);
        int cyc;
        nb = 0;
        stable = 1'b1;
        cyc = 0;
        while (DONE !== 1'b1 && cyc < 30) begin
            if (BUSY === 1'b1) nb++;
            if (SUM !== prev) stable = 1'b0;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin,
                      input logic [W:0] exp);
        logic [W-1:0] prev;
        int nb;
        bit stable;
        prev = SUM;
        @(negedge CLK);
        A = a;
        B = b;
        CIN = cin;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(prev, nb, stable);
        chk({name, " busy_cycles"}, nb, W);
        chk({name, " sum_stable"}, {31'd0, stable}, 1);
        chk({name, " done"}, {31'd0, DONE}, 1);
        chk({name, " result"}, {23'd0, COUT, SUM}, {23'd0, exp});
        @(negedge CLK);
        chk({name, " done_1cyc"}, {30'd0, DONE, BUSY}, 0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   model;
        int nb;
        int ndone;
        bit stable;

        n_chk = 0;
        n_fail = 0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        RSTn = 1'b0;
        START = 1'b0;
        A = '0;
        B = '0;
        CIN = 1'b0;
        #2;
        chk("reset_outputs", {21'd0, BUSY, DONE, COUT, SUM}, 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        chk("idle_after_reset", {30'd0, BUSY, DONE}, 0);

        for (int i = 0; i < 6; i++) begin
            op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
               {vecs[i].cout, vecs[i].sum});
        end

        // START during RUN is ignored.
        @(negedge CLK);
        A = 8'h12;
        B = 8'h34;
        CIN = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        A = 8'h00;
        B = 8'h00;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (DONE === 1'b1) begin
                ndone++;
                chk("ignore_result", {23'd0, COUT, SUM}, 9'h046);
            end
            @(negedge CLK);
        end
        chk("ignore_done_count", ndone, 1);

        // START held in FIN chains straight into the next operation.
        op("chain_first", 8'h5A, 8'h3C, 1'b0, 9'h096);
        @(negedge CLK);
        A = 8'h01;
        B = 8'h02;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(8'h96, nb, stable);
        chk("chain_prior_done", {23'd0, COUT, SUM}, 9'h003);
        A = 8'h10;
        B = 8'h20;
        CIN = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("chain_busy_again", {30'd0, BUSY, DONE}, 2);
        chk("chain_sum_held", SUM, 8'h03);
        wait_done(8'h03, nb, stable);
        chk("chain_busy_cycles", nb, W);
        chk("chain_done", {31'd0, DONE}, 1);
        chk("chain_result", {23'd0, COUT, SUM}, 9'h030);

        // Reset mid-RUN between edges.
        op("pre_reset", 8'hF0, 8'h0F, 1'b1, 9'h100);
        @(negedge CLK);
        A = 8'h5A;
        B = 8'h3C;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        chk("async_reset", {21'd0, BUSY, DONE, COUT, SUM}, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (DONE === 1'b1) ndone++;
            @(negedge CLK);
        end
        chk("no_done_after_abort", ndone, 0);
        op("post_reset", 8'h01, 8'h01, 1'b0, 9'h002);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            op($sformatf("rand%0d", i), ra, rb, rc, model);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
